ghost_map_writer: RTL and testbench

- Downstream stage of the ghost location controller.
- Takes each ghost's current and next grid cell and commits the move into the shared board map RAM:
  - restores the tile each ghost was covering;
  - saves the tile under each new cell;
  - writes the GHOST tile code into each new cell.
- Pulses wrdone when the commit is finished; the controller then advances curr <= next.
- Reports ghost-on-pacman collisions and illegal wall moves.

---
 rtl/ghost_pkg.sv | 34 +++
 rtl/ghost_tile_classify.sv | 30 +++
 rtl/ghost_map_writer.sv | 164 ++++++++++++++++
 tb/tb_ghost_map_writer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// Shared definitions for the ghost datapath: map tile codes, writer FSM states and ghost start cells.
package ghost_pkg;

    localparam int TILE_BITS = 3;

    typedef logic [TILE_BITS-1:0] tile_t;

    localparam tile_t EMPTY  = 3'd0;
    localparam tile_t WALL   = 3'd1;
    localparam tile_t PILL   = 3'd2;
    localparam tile_t ENERGY = 3'd3;
    localparam tile_t PACMAN = 3'd4;
    localparam tile_t GHOST  = 3'd5;

    typedef enum logic [3:0] {
        IDLE,
        ERASE2,
        ERASE1,
        RD1,
        WAIT1,
        WR1,
        RD2,
        WAIT2,
        WR2,
        DONE,
        SETTLE
    } map_wr_state_t;

    localparam int GHOST1_START_X = 16;
    localparam int GHOST1_START_Y = 13;
    localparam int GHOST2_START_X = 23;
    localparam int GHOST2_START_Y = 13;

endpackage

// File: rtl/ghost_tile_classify.sv
// Decides what a ghost must restore later when it steps onto a tile, and flags pacman/wall hits.
module ghost_tile_classify
    import ghost_pkg::*;
(
    input  tile_t tile,
    output tile_t saved,
    output logic  hit_pacman,
    output logic  hit_wall
);

    // Pacman and other ghosts are never remembered as the background tile.
    always_comb begin
        saved      = tile;
        hit_pacman = 1'b0;
        hit_wall   = 1'b0;
        case (tile)
            PACMAN: begin
                saved      = EMPTY;
                hit_pacman = 1'b1;
            end
            WALL: begin
                saved    = WALL;
                hit_wall = 1'b1;
            end
            GHOST:   saved = EMPTY;
            default: saved = tile;
        endcase
    end

endmodule

// File: rtl/ghost_map_writer.sv
// Commits both ghosts' moves into the board map RAM: erase old cells, save new tiles, draw GHOST.
module ghost_map_writer
    import ghost_pkg::*;
#(
    parameter int X_W    = 6,
    parameter int Y_W    = 5,
    parameter int TILE_W = TILE_BITS
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [X_W-1:0]    curr_ghost1_x,
    input  logic [Y_W-1:0]    curr_ghost1_y,
    input  logic [X_W-1:0]    curr_ghost2_x,
    input  logic [Y_W-1:0]    curr_ghost2_y,
    input  logic [X_W-1:0]    next_ghost1_x,
    input  logic [Y_W-1:0]    next_ghost1_y,
    input  logic [X_W-1:0]    next_ghost2_x,
    input  logic [Y_W-1:0]    next_ghost2_y,
    input  logic [TILE_W-1:0] map_rd_data,
    output logic [X_W-1:0]    map_addr_x,
    output logic [Y_W-1:0]    map_addr_y,
    output logic              map_wr_en,
    output logic [TILE_W-1:0] map_wr_data,
    output logic              wrdone,
    output logic [1:0]        collision_type,
    output logic              wall_err,
    output logic              busy
);

    map_wr_state_t state;
    tile_t         saved1, saved2;
    logic          first_flag;
    logic [X_W-1:0] c1x, c2x, n1x, n2x;
    logic [Y_W-1:0] c1y, c2y, n1y, n2y;

    tile_t cls1_saved, cls2_saved;
    logic  cls1_pacman, cls1_wall, cls2_pacman, cls2_wall;
    logic  trigger, same_next;

    assign trigger = first_flag
                   || ({next_ghost1_x, next_ghost1_y} != {curr_ghost1_x, curr_ghost1_y})
                   || ({next_ghost2_x, next_ghost2_y} != {curr_ghost2_x, curr_ghost2_y});
    assign same_next = ({n1x, n1y} == {n2x, n2y});

    ghost_tile_classify u_classify1 (
        .tile       (map_rd_data),
        .saved      (cls1_saved),
        .hit_pacman (cls1_pacman),
        .hit_wall   (cls1_wall)
    );

    ghost_tile_classify u_classify2 (
        .tile       (map_rd_data),
        .saved      (cls2_saved),
        .hit_pacman (cls2_pacman),
        .hit_wall   (cls2_wall)
    );

    // Outputs are loaded on the edge that enters a state, so each bus value is valid for that state's whole cycle.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state          <= IDLE;
            saved1         <= EMPTY;
            saved2         <= EMPTY;
            first_flag     <= 1'b1;
            c1x <= '0; c1y <= '0; c2x <= '0; c2y <= '0;
            n1x <= '0; n1y <= '0; n2x <= '0; n2y <= '0;
            map_addr_x     <= '0;
            map_addr_y     <= '0;
            map_wr_en      <= 1'b0;
            map_wr_data    <= '0;
            wrdone         <= 1'b0;
            collision_type <= 2'b00;
            wall_err       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    map_addr_x  <= '0;
                    map_addr_y  <= '0;
                    map_wr_en   <= 1'b0;
                    map_wr_data <= '0;
                    wrdone      <= 1'b0;
                    if (trigger) begin
                        first_flag     <= 1'b0;
                        collision_type <= 2'b00;
                        c1x <= curr_ghost1_x; c1y <= curr_ghost1_y;
                        c2x <= curr_ghost2_x; c2y <= curr_ghost2_y;
                        n1x <= next_ghost1_x; n1y <= next_ghost1_y;
                        n2x <= next_ghost2_x; n2y <= next_ghost2_y;
                        map_addr_x  <= curr_ghost2_x;
                        map_addr_y  <= curr_ghost2_y;
                        map_wr_en   <= 1'b1;
                        map_wr_data <= saved2;
                        busy        <= 1'b1;
                        state       <= ERASE2;
                    end
                end
                ERASE2: begin
                    map_addr_x  <= c1x;
                    map_addr_y  <= c1y;
                    map_wr_data <= saved1;
                    state       <= ERASE1;
                end
                ERASE1: begin
                    map_addr_x  <= n1x;
                    map_addr_y  <= n1y;
                    map_wr_en   <= 1'b0;
                    map_wr_data <= '0;
                    state       <= RD1;
                end
                RD1: state <= WAIT1;
                WAIT1: begin
                    saved1            <= cls1_saved;
                    collision_type[0] <= cls1_pacman;
                    if (cls1_wall) wall_err <= 1'b1;
                    map_wr_en   <= 1'b1;
                    map_wr_data <= GHOST;
                    state       <= WR1;
                end
                WR1: begin
                    map_addr_x  <= n2x;
                    map_addr_y  <= n2y;
                    map_wr_en   <= 1'b0;
                    map_wr_data <= '0;
                    state       <= RD2;
                end
                RD2: state <= WAIT2;
                // A shared target cell already holds ghost1's GHOST, so reuse ghost1's classification.
                WAIT2: begin
                    if (same_next) begin
                        saved2            <= saved1;
                        collision_type[1] <= collision_type[0];
                    end else begin
                        saved2            <= cls2_saved;
                        collision_type[1] <= cls2_pacman;
                        if (cls2_wall) wall_err <= 1'b1;
                    end
                    map_wr_en   <= 1'b1;
                    map_wr_data <= GHOST;
                    state       <= WR2;
                end
                WR2: begin
                    map_addr_x  <= '0;
                    map_addr_y  <= '0;
                    map_wr_en   <= 1'b0;
                    map_wr_data <= '0;
                    wrdone      <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    wrdone <= 1'b0;
                    state  <= SETTLE;
                end
                SETTLE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_map_writer.sv
// Directed bench for ghost_map_writer with a map RAM model and a commit-level reference model.
module tb_ghost_map_writer;
    import ghost_pkg::*;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b1;
    logic [5:0] c1x, c2x, n1x, n2x;
    logic [4:0] c1y, c2y, n1y, n2y;
    logic [2:0] map_rd_data;
    logic [5:0] map_addr_x;
    logic [4:0] map_addr_y;
    logic       map_wr_en;
    logic [2:0] map_wr_data;
    logic       wrdone;
    logic [1:0] collision_type;
    logic       wall_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    ghost_map_writer dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .curr_ghost1_x  (c1x),
        .curr_ghost1_y  (c1y),
        .curr_ghost2_x  (c2x),
        .curr_ghost2_y  (c2y),
        .next_ghost1_x  (n1x),
        .next_ghost1_y  (n1y),
        .next_ghost2_x  (n2x),
        .next_ghost2_y  (n2y),
        .map_rd_data    (map_rd_data),
        .map_addr_x     (map_addr_x),
        .map_addr_y     (map_addr_y),
        .map_wr_en      (map_wr_en),
        .map_wr_data    (map_wr_data),
        .wrdone         (wrdone),
        .collision_type (collision_type),
        .wall_err       (wall_err),
        .busy           (busy)
    );

    function automatic logic [2:0] initTile(input int x, input int y);
        if (x == 16 && y == 12) return PILL;
        if (x == 20 && y == 20) return PACMAN;
        if (x == 18 && y == 13) return ENERGY;
        if (x == 0 && y == 0)   return WALL;
        return EMPTY;
    endfunction

    // Board RAM: synchronous write, registered read data
    logic [2:0] ram [64][32];
    always @(posedge CLOCK_50) begin
        if (load) begin
            for (int x = 0; x < 64; x++)
                for (int y = 0; y < 32; y++)
                    ram[x][y] <= initTile(x, y);
        end else if (map_wr_en) begin
            ram[map_addr_x][map_addr_y] <= map_wr_data;
        end
        map_rd_data <= ram[map_addr_x][map_addr_y];
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void classify(input logic [2:0] t, output logic [2:0] s,
                                     output logic pac, output logic wl);
        s = t; pac = 1'b0; wl = 1'b0;
        if (t == PACMAN) begin s = EMPTY; pac = 1'b1; end
        else if (t == WALL) wl = 1'b1;
        else if (t == GHOST) s = EMPTY;
    endfunction

    // Reference model: golden map plus the tiles/flags each commit must leave behind
    logic [2:0] gm [64][32];
    int         ph = 0;
    logic       valid = 1'b0;
    logic       m_first;
    logic [2:0] m_s1, m_s2, p_s1, p_s2;
    logic [1:0] m_coll, p_coll;
    logic       m_wall, p_wall;
    logic [5:0] wx [11];
    logic [4:0] wy [11];
    logic [2:0] wd [11];
    logic [5:0] r1x, r2x;
    logic [4:0] r1y, r2y;

    function automatic logic [2:0] tileAfterErase(input logic [5:0] x, input logic [4:0] y);
        if ({x, y} == {c1x, c1y}) return m_s1;
        if ({x, y} == {c2x, c2y}) return m_s2;
        return gm[x][y];
    endfunction

    task automatic planCommit();
        logic [2:0] t;
        logic pac, wl;
        wx[1] = c2x; wy[1] = c2y; wd[1] = m_s2;
        wx[2] = c1x; wy[2] = c1y; wd[2] = m_s1;
        wx[5] = n1x; wy[5] = n1y; wd[5] = GHOST;
        wx[8] = n2x; wy[8] = n2y; wd[8] = GHOST;
        r1x = n1x; r1y = n1y; r2x = n2x; r2y = n2y;
        t = tileAfterErase(n1x, n1y);
        classify(t, p_s1, pac, wl);
        p_coll = {1'b0, pac};
        p_wall = m_wall | wl;
        if ({n1x, n1y} == {n2x, n2y}) begin
            p_s2 = p_s1;
            p_coll[1] = pac;
        end else begin
            t = tileAfterErase(n2x, n2y);
            classify(t, p_s2, pac, wl);
            p_coll[1] = pac;
            p_wall = p_wall | wl;
        end
    endtask

    // Per-cycle comparison against the commit timetable, then advance the model
    always @(negedge CLOCK_50) begin
        if (load)
            for (int x = 0; x < 64; x++)
                for (int y = 0; y < 32; y++)
                    gm[x][y] = initTile(x, y);
        if (valid) begin
            if (ph == 0 || ph == 9 || ph == 10) begin
                checkOutput($sformatf("busy_ph%0d", ph), busy, (ph != 0) ? 1 : 0);
                checkOutput($sformatf("wrdone_ph%0d", ph), wrdone, (ph == 9) ? 1 : 0);
                checkOutput($sformatf("wr_en_ph%0d", ph), map_wr_en, 0);
                checkOutput($sformatf("addr_x_ph%0d", ph), map_addr_x, 0);
                checkOutput($sformatf("addr_y_ph%0d", ph), map_addr_y, 0);
                checkOutput($sformatf("wr_data_ph%0d", ph), map_wr_data, 0);
                checkOutput($sformatf("collision_ph%0d", ph), collision_type, m_coll);
                checkOutput($sformatf("wall_err_ph%0d", ph), wall_err, m_wall);
            end else begin
                checkOutput($sformatf("busy_ph%0d", ph), busy, 1);
                checkOutput($sformatf("wrdone_ph%0d", ph), wrdone, 0);
                if (ph == 1 || ph == 2 || ph == 5 || ph == 8) begin
                    checkOutput($sformatf("wr_en_ph%0d", ph), map_wr_en, 1);
                    checkOutput($sformatf("addr_x_ph%0d", ph), map_addr_x, wx[ph]);
                    checkOutput($sformatf("addr_y_ph%0d", ph), map_addr_y, wy[ph]);
                    checkOutput($sformatf("wr_data_ph%0d", ph), map_wr_data, wd[ph]);
                    gm[wx[ph]][wy[ph]] = wd[ph];
                end else begin
                    checkOutput($sformatf("wr_en_ph%0d", ph), map_wr_en, 0);
                end
                if (ph == 3) begin
                    checkOutput("rd1_addr", {map_addr_x, map_addr_y}, {r1x, r1y});
                end
                if (ph == 6) begin
                    checkOutput("rd2_addr", {map_addr_x, map_addr_y}, {r2x, r2y});
                end
            end
        end
        if (reset) begin
            valid = 1'b1; ph = 0; m_first = 1'b1;
            m_s1 = EMPTY; m_s2 = EMPTY; m_coll = 2'b00; m_wall = 1'b0;
        end else if (valid) begin
            if (ph == 8) begin
                m_s1 = p_s1; m_s2 = p_s2; m_coll = p_coll; m_wall = p_wall;
            end
            if (ph == 0) begin
                if (m_first || {n1x, n1y} != {c1x, c1y} || {n2x, n2y} != {c2x, c2y}) begin
                    planCommit();
                    m_first = 1'b0;
                    ph = 1;
                end
            end else if (ph == 10) ph = 0;
            else ph++;
        end
    end

    task automatic waitDone(output int edges);
        bit seen = 0;
        edges = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(posedge CLOCK_50); #2;
            if (wrdone) begin seen = 1; edges = i; end
        end
        if (!seen) checkOutput("wrdone_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input int a1x, input int a1y, input int a2x, input int a2y);
        int e;
        @(posedge CLOCK_50); #2;
        n1x = 6'(a1x); n1y = 5'(a1y); n2x = 6'(a2x); n2y = 5'(a2y);
        waitDone(e);
        c1x = n1x; c1y = n1y; c2x = n2x; c2y = n2y;
        repeat (2) @(posedge CLOCK_50);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e;
        c1x = 6'(GHOST1_START_X); c1y = 5'(GHOST1_START_Y);
        c2x = 6'(GHOST2_START_X); c2y = 5'(GHOST2_START_Y);
        n1x = c1x; n1y = c1y; n2x = c2x; n2y = c2y;
        repeat (3) @(posedge CLOCK_50);
        #2;
        reset = 1'b0;
        load  = 1'b0;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_collision", collision_type, 0);
        checkOutput("reset_wall_err", wall_err, 0);

        // Forced first commit with nothing moving
        waitDone(e);
        checkOutput("first_wrdone_edges", e, 9);
        repeat (2) @(posedge CLOCK_50);
        #2;
        checkOutput("first_g1_drawn", ram[16][13], GHOST);
        checkOutput("first_g2_drawn", ram[23][13], GHOST);

        applyStimulus(16, 12, 23, 13);
        checkOutput("pill_cell_ghost", ram[16][12], GHOST);
        checkOutput("start1_restored", ram[16][13], EMPTY);
        applyStimulus(16, 11, 23, 13);
        checkOutput("pill_restored", ram[16][12], PILL);
        checkOutput("g1_at_16_11", ram[16][11], GHOST);

        applyStimulus(16, 11, 20, 20);
        checkOutput("pacman_collision", collision_type, 2);
        checkOutput("pacman_cell_ghost", ram[20][20], GHOST);
        checkOutput("start2_restored", ram[23][13], EMPTY);

        applyStimulus(18, 13, 18, 13);
        checkOutput("shared_cell_ghost", ram[18][13], GHOST);
        checkOutput("shared_collision", collision_type, 0);
        checkOutput("eaten_pacman_empty", ram[20][20], EMPTY);
        applyStimulus(17, 13, 19, 13);
        checkOutput("energy_restored", ram[18][13], ENERGY);
        checkOutput("g1_at_17_13", ram[17][13], GHOST);

        applyStimulus(0, 0, 19, 13);
        checkOutput("wall_err_set", wall_err, 1);
        checkOutput("wall_cell_ghost", ram[0][0], GHOST);
        applyStimulus(1, 0, 19, 13);
        checkOutput("wall_err_sticky", wall_err, 1);
        checkOutput("wall_restored", ram[0][0], WALL);

        // Reset while ghost1's GHOST write is on the bus
        @(posedge CLOCK_50); #2;
        n1x = 6'd2; n1y = 5'd0;
        repeat (5) @(posedge CLOCK_50);
        #2;
        checkOutput("wr1_write_strobe", map_wr_en, 1);
        reset = 1'b1;
        @(posedge CLOCK_50); #2;
        reset = 1'b0;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_wrdone", wrdone, 0);
        checkOutput("midreset_wr_en", map_wr_en, 0);
        checkOutput("midreset_collision", collision_type, 0);
        checkOutput("midreset_wall_err", wall_err, 0);
        waitDone(e);
        checkOutput("post_reset_commit_edges", e, 9);
        c1x = n1x; c1y = n1y;
        repeat (3) @(posedge CLOCK_50);
        #2;
        checkOutput("post_reset_g1_drawn", ram[2][0], GHOST);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
